counter_cmd_sequencer: RTL and testbench
========================================

Name: counter_cmd_sequencer

Overview:
- Upstream stage of the multi-mode game counter.
- Accepts queued commands from a host over a valid/ready handshake. Each command carries a count mode, an optional preload value and a dwell time.
- Drives the counter's CONTROL_SIGNALS, initial-value and INIT_SIGNAL inputs for the programmed dwell.
- Watches the counter's GAMEOVER output to flush the queue and halt until the host resumes.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2)
- DWELL_W, 8, width of per-command dwell field
- VAL_W, 4, width of preload value (matches counter width)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  sequencer can accept command
- cmd_mode  in  2  00 up+1, 01 up+2, 10 down-1, 11 down-2
- cmd_load  in  1  1 = preload counter before running
- cmd_value  in  VAL_W  preload value
- cmd_dwell  in  DWELL_W  run cycles for this command (0 treated as 1)
- gameover  in  1  GAMEOVER from counter
- resume  in  1  host pulse releasing HALT
- control_signals  out  2  to counter CONTROL_SIGNALS
- init_value  out  VAL_W  to counter initial value
- init_signal  out  1  to counter INIT_SIGNAL
- busy  out  1  state is LOAD or RUN
- halted  out  1  state is HALT
- fifo_level  out  $clog2(DEPTH)+1  queued command count

Behaviour:
- Reset (rst=0, async): state IDLE, FIFO empty, control_signals=00, init_value=0, init_signal=0, busy=0, halted=0, fifo_level=0, dwell counter=0.
- cmd_ready = (fifo_level<DEPTH) && state!=HALT && !gameover.
  - Combinational from registered level; at full, ready=0 even if a pop occurs the same cycle.
  - A push occurs on valid&&ready.
- Push and pop in the same cycle: level unchanged, both take effect.
- All outputs are registered; a popped command is visible on outputs the cycle after the pop edge.
- FSM states: IDLE, LOAD, RUN, HALT.
  - IDLE: FIFO non-empty -> pop head into current-command register. Go to LOAD if load=1, else RUN. control_signals holds the last mode while idle.
  - LOAD: one cycle. init_signal=1, init_value=cmd.value, control_signals=cmd.mode. Next state RUN.
  - RUN: init_signal=0, dwell counter loaded with max(dwell,1) and decremented each cycle.
    - On the last RUN cycle with FIFO non-empty: pop the next command directly (no IDLE bubble) and go to LOAD or RUN.
    - On the last RUN cycle with FIFO empty: go to IDLE.
  - HALT: entered from any state on the cycle gameover is sampled 1.
    - Entry: FIFO flushed (level=0), current command discarded, init_signal=0, control_signals held.
    - Exit to IDLE when resume=1 && gameover=0. resume is ignored outside HALT or while gameover=1.
- gameover has priority over pop, push and dwell expiry in the same cycle.
- init_signal is never high for more than one consecutive cycle per command. Two back-to-back load commands give two separate pulses with a RUN of >=1 cycle between them.
- The dwell counter does not wrap. Max dwell is 2^DWELL_W-1 cycles.
- FIFO pointers wrap modulo DEPTH. The level counter saturates logically via cmd_ready, so overflow and underflow are impossible.

Optional Feature:
- SEQ_LOOP_EN:
  - When defined: adds input loop_en (1 bit). While loop_en=1, each command popped is simultaneously re-pushed at the tail, so the queue replays cyclically; cmd_ready=0 while loop_en=1. Loop re-push is suppressed by gameover (flush wins).
  - When undefined: no loop_en port; commands are consumed once.

Decomposition:
- Package counter_seq_pkg:
  - mode_e enum (UP1=2'b00, UP2=2'b01, DN1=2'b10, DN2=2'b11)
  - seq_state_e (IDLE, LOAD, RUN, HALT)
  - cmd_t packed struct {mode, load, value, dwell}
  - default-width localparams
- Sub-module seq_cmd_fifo: synchronous FIFO of cmd_t with push/pop/flush, level, full, empty; async active-low reset.

Test Plan:
- Reset mid-RUN (rst=0 for 1 cycle) -> all outputs 0 immediately, fifo_level=0, state IDLE.
- Push {mode=01, load=1, value=4'h3, dwell=5} -> one cycle init_signal=1, init_value=3, then control_signals=01 for 5 cycles, busy deasserts after.
- Push 4 commands with dwell=0,2,0,1 back-to-back -> cmd_ready=0 at level 4; modes change on consecutive edges without IDLE gaps; each dwell=0 runs exactly 1 cycle.
- Push at full while a pop occurs -> push refused (ready=0), level drops 4->3 next cycle.
- gameover=1 during RUN with 3 queued -> next cycle halted=1, fifo_level=0, cmd_ready=0. resume while gameover=1 is ignored; resume after gameover=0 -> IDLE.
- With SEQ_LOOP_EN, loop_en=1, 2 queued commands (dwell 2, 3) -> modes alternate indefinitely at 2/3-cycle cadence, fifo_level stays 2.

Source files
------------

// File: rtl/counter_cmd_sequencer_pkg.sv
// Shared types for the game-counter command sequencer: count modes, FSM states
// and the default command record layout.
package counter_seq_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_DWELL_W = 8;
  localparam int DEF_VAL_W   = 4;

  typedef enum logic [1:0] {
    UP1 = 2'b00,
    UP2 = 2'b01,
    DN1 = 2'b10,
    DN2 = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    HALT
  } seq_state_e;

  typedef struct packed {
    mode_e                  mode;
    logic                   load;
    logic [DEF_VAL_W-1:0]   value;
    logic [DEF_DWELL_W-1:0] dwell;
  } cmd_t;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Command FIFO with push/pop/flush and a registered occupancy count.
// Head is read combinationally so a pop can capture it on the same edge.
module seq_cmd_fifo
  import counter_seq_pkg::*;
#(
  parameter int  DEPTH = DEF_DEPTH,
  parameter type T     = cmd_t,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  input  logic          flush,
  output T              head,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [LW-1:0]  level_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      // Simultaneous push and pop leaves the count unchanged.
      if (push && !pop)      level_reg <= level_reg + LW'(1);
      else if (pop && !push) level_reg <= level_reg - LW'(1);
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;
  assign full  = (level_reg == LW'(DEPTH));
  assign empty = (level_reg == '0);

endmodule

// File: rtl/counter_cmd_sequencer.sv
// Feeds queued host commands to the game counter and halts on GAMEOVER.
// Optional SEQ_LOOP_EN adds loop_en, which replays the queue cyclically.
module counter_cmd_sequencer
  import counter_seq_pkg::*;
#(
  parameter int  DEPTH   = DEF_DEPTH,
  parameter int  DWELL_W = DEF_DWELL_W,
  parameter int  VAL_W   = DEF_VAL_W,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_mode,
  input  logic               cmd_load,
  input  logic [VAL_W-1:0]   cmd_value,
  input  logic [DWELL_W-1:0] cmd_dwell,
  input  logic               gameover,
  input  logic               resume,
`ifdef SEQ_LOOP_EN
  input  logic               loop_en,
`endif
  output logic [1:0]         control_signals,
  output logic [VAL_W-1:0]   init_value,
  output logic               init_signal,
  output logic               busy,
  output logic               halted,
  output logic [LVL_W-1:0]   fifo_level
);

  typedef struct packed {
    mode_e              mode;
    logic               load;
    logic [VAL_W-1:0]   value;
    logic [DWELL_W-1:0] dwell;
  } cmd_w_t;

  seq_state_e         state_reg;
  logic [DWELL_W-1:0] dwell_cnt_reg;
  cmd_w_t             host_cmd, push_cmd, head_cmd;
  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic               last_run;
  logic [DWELL_W-1:0] head_dwell;

  assign host_cmd = '{mode: mode_e'(cmd_mode), load: cmd_load,
                      value: cmd_value, dwell: cmd_dwell};

  assign last_run   = (state_reg == RUN) && (dwell_cnt_reg == DWELL_W'(1));
  assign fifo_pop   = !gameover && !fifo_empty && ((state_reg == IDLE) || last_run);
  assign head_dwell = (head_cmd.dwell == '0) ? DWELL_W'(1) : head_cmd.dwell;

`ifdef SEQ_LOOP_EN
  assign cmd_ready = !fifo_full && (state_reg != HALT) && !gameover && !loop_en;
  // fifo_pop already excludes gameover, so a flush always beats the replay.
  assign fifo_push = (cmd_valid && cmd_ready) || (loop_en && fifo_pop);
  assign push_cmd  = loop_en ? head_cmd : host_cmd;
`else
  assign cmd_ready = !fifo_full && (state_reg != HALT) && !gameover;
  assign fifo_push = cmd_valid && cmd_ready;
  assign push_cmd  = host_cmd;
`endif

  seq_cmd_fifo #(
    .DEPTH (DEPTH),
    .T     (cmd_w_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_cmd),
    .pop       (fifo_pop),
    .flush     (gameover),
    .head      (head_cmd),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The outputs plus dwell_cnt_reg together form the current-command register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      dwell_cnt_reg   <= '0;
      control_signals <= 2'b00;
      init_value      <= '0;
      init_signal     <= 1'b0;
      busy            <= 1'b0;
      halted          <= 1'b0;
    end else if (gameover) begin
      state_reg     <= HALT;
      dwell_cnt_reg <= '0;
      init_signal   <= 1'b0;
      busy          <= 1'b0;
      halted        <= 1'b1;
    end else begin
      case (state_reg)
        IDLE, RUN: begin
          if (fifo_pop) begin
            control_signals <= head_cmd.mode;
            dwell_cnt_reg   <= head_dwell;
            busy            <= 1'b1;
            if (head_cmd.load) begin
              state_reg   <= LOAD;
              init_signal <= 1'b1;
              init_value  <= head_cmd.value;
            end else begin
              state_reg   <= RUN;
              init_signal <= 1'b0;
            end
          end else if (state_reg == RUN) begin
            init_signal   <= 1'b0;
            dwell_cnt_reg <= dwell_cnt_reg - DWELL_W'(1);
            if (last_run) begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        LOAD: begin
          state_reg   <= RUN;
          init_signal <= 1'b0;
        end
        HALT: begin
          if (resume) begin
            state_reg <= IDLE;
            halted    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Directed vector bench for counter_cmd_sequencer (default parameters).
// Define SEQ_LOOP_EN to also exercise queue replay.
module tb_counter_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_mode = 2'b00;
  logic       cmd_load = 1'b0;
  logic [3:0] cmd_value = 4'h0;
  logic [7:0] cmd_dwell = 8'h00;
  logic       gameover = 1'b0;
  logic       resume = 1'b0;
`ifdef SEQ_LOOP_EN
  logic       loop_en = 1'b0;
`endif
  logic [1:0] control_signals;
  logic [3:0] init_value;
  logic       init_signal;
  logic       busy;
  logic       halted;
  logic [2:0] fifo_level;

  int n_cmp = 0;
  int n_bad = 0;

  counter_cmd_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_mode        (cmd_mode),
    .cmd_load        (cmd_load),
    .cmd_value       (cmd_value),
    .cmd_dwell       (cmd_dwell),
    .gameover        (gameover),
    .resume          (resume),
`ifdef SEQ_LOOP_EN
    .loop_en         (loop_en),
`endif
    .control_signals (control_signals),
    .init_value      (init_value),
    .init_signal     (init_signal),
    .busy            (busy),
    .halted          (halted),
    .fifo_level      (fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [1:0] mode;
    logic       load;
    logic [3:0] value;
    logic [7:0] dwell;
    logic       gov;
    logic       res;
    logic       exp_ready;
    logic [1:0] exp_ctrl;
    logic       exp_init;
    logic [3:0] exp_ival;
    logic       exp_busy;
    logic       exp_halt;
    logic [2:0] exp_lvl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic valid, logic [1:0] mode, logic load, logic [3:0] value,
                              logic [7:0] dwell, logic gov, logic res, logic rdy,
                              logic [1:0] ctrl, logic init, logic [3:0] ival,
                              logic bsy, logic hlt, logic [2:0] lvl);
    vec_t v;
    v.valid = valid; v.mode = mode; v.load = load; v.value = value; v.dwell = dwell;
    v.gov = gov; v.res = res; v.exp_ready = rdy; v.exp_ctrl = ctrl; v.exp_init = init;
    v.exp_ival = ival; v.exp_busy = bsy; v.exp_halt = hlt; v.exp_lvl = lvl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic valid, logic [1:0] mode, logic load, logic [3:0] value, logic [7:0] dwell);
    cmd_valid = valid; cmd_mode = mode; cmd_load = load; cmd_value = value; cmd_dwell = dwell;
  endtask

  task automatic chk_all(string tag, logic [1:0] ctrl, logic init, logic [3:0] ival,
                         logic bsy, logic hlt, logic [2:0] lvl);
    chk({tag, " ctrl"}, control_signals, ctrl);
    chk({tag, " init"}, init_signal, init);
    chk({tag, " ival"}, init_value, ival);
    chk({tag, " busy"}, busy, bsy);
    chk({tag, " halted"}, halted, hlt);
    chk({tag, " level"}, fifo_level, lvl);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single load command, dwell 5
    vecs.push_back(mk(1, 2'd1, 1, 4'd3, 8'd5, 0, 0, 1, 2'd0, 0, 4'd0, 0, 0, 3'd1));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd1, 1, 4'd3, 1, 0, 3'd0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd1, 0, 4'd3, 1, 0, 3'd0));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd1, 0, 4'd3, 0, 0, 3'd0));
    // Long command, then fill to 4 with dwell 0,2,0,1; push at full refused
    vecs.push_back(mk(1, 2'd0, 0, 4'd0, 8'd6, 0, 0, 1, 2'd1, 0, 4'd3, 0, 0, 3'd1));
    vecs.push_back(mk(1, 2'd2, 0, 4'd0, 8'd0, 0, 0, 1, 2'd0, 0, 4'd3, 1, 0, 3'd1));
    vecs.push_back(mk(1, 2'd3, 0, 4'd0, 8'd2, 0, 0, 1, 2'd0, 0, 4'd3, 1, 0, 3'd2));
    vecs.push_back(mk(1, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd0, 0, 4'd3, 1, 0, 3'd3));
    vecs.push_back(mk(1, 2'd1, 0, 4'd0, 8'd1, 0, 0, 1, 2'd0, 0, 4'd3, 1, 0, 3'd4));
    vecs.push_back(mk(1, 2'd2, 0, 4'd0, 8'd9, 0, 0, 0, 2'd0, 0, 4'd3, 1, 0, 3'd4));
    vecs.push_back(mk(1, 2'd2, 0, 4'd0, 8'd9, 0, 0, 0, 2'd0, 0, 4'd3, 1, 0, 3'd4));
    vecs.push_back(mk(1, 2'd2, 0, 4'd0, 8'd9, 0, 0, 0, 2'd2, 0, 4'd3, 1, 0, 3'd3));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd3, 0, 4'd3, 1, 0, 3'd2));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd3, 0, 4'd3, 1, 0, 3'd2));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd0, 0, 4'd3, 1, 0, 3'd1));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd1, 0, 4'd3, 1, 0, 3'd0));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd1, 0, 4'd3, 0, 0, 3'd0));
    // Gameover during RUN with 3 queued, resume handling
    vecs.push_back(mk(1, 2'd2, 0, 4'd0, 8'd8, 0, 0, 1, 2'd1, 0, 4'd3, 0, 0, 3'd1));
    vecs.push_back(mk(1, 2'd3, 0, 4'd0, 8'd1, 0, 0, 1, 2'd2, 0, 4'd3, 1, 0, 3'd1));
    vecs.push_back(mk(1, 2'd1, 0, 4'd0, 8'd1, 0, 0, 1, 2'd2, 0, 4'd3, 1, 0, 3'd2));
    vecs.push_back(mk(1, 2'd0, 0, 4'd0, 8'd1, 0, 0, 1, 2'd2, 0, 4'd3, 1, 0, 3'd3));
    vecs.push_back(mk(1, 2'd3, 0, 4'd0, 8'd1, 1, 0, 0, 2'd2, 0, 4'd3, 0, 1, 3'd0));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 1, 1, 0, 2'd2, 0, 4'd3, 0, 1, 3'd0));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 0, 2'd2, 0, 4'd3, 0, 1, 3'd0));
    vecs.push_back(mk(1, 2'd1, 0, 4'd0, 8'd1, 0, 1, 0, 2'd2, 0, 4'd3, 0, 0, 3'd0));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd2, 0, 4'd3, 0, 0, 3'd0));
    // Back-to-back load commands with dwell 0: separate init pulses
    vecs.push_back(mk(1, 2'd1, 1, 4'd5, 8'd0, 0, 0, 1, 2'd2, 0, 4'd3, 0, 0, 3'd1));
    vecs.push_back(mk(1, 2'd2, 1, 4'd9, 8'd0, 0, 0, 1, 2'd1, 1, 4'd5, 1, 0, 3'd1));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd1, 0, 4'd5, 1, 0, 3'd1));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd2, 1, 4'd9, 1, 0, 3'd0));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd2, 0, 4'd9, 1, 0, 3'd0));
    vecs.push_back(mk(0, 2'd0, 0, 4'd0, 8'd0, 0, 0, 1, 2'd2, 0, 4'd9, 0, 0, 3'd0));

    // Reset state
    #3;
    chk_all("reset", 2'd0, 0, 4'd0, 0, 0, 3'd0);
    step();
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].valid, vecs[i].mode, vecs[i].load, vecs[i].value, vecs[i].dwell);
      gameover = vecs[i].gov;
      resume   = vecs[i].res;
      #1;
      chk($sformatf("row%0d ready", i), cmd_ready, vecs[i].exp_ready);
      step();
      chk_all($sformatf("row%0d", i), vecs[i].exp_ctrl, vecs[i].exp_init, vecs[i].exp_ival,
              vecs[i].exp_busy, vecs[i].exp_halt, vecs[i].exp_lvl);
    end
    gameover = 1'b0;
    resume   = 1'b0;

    // Reset asserted mid-RUN clears everything without waiting for a clock
    drive(1, 2'd3, 1, 4'd7, 8'd20);
    step();
    drive(1, 2'd1, 0, 4'd0, 8'd4);
    step();
    drive(0, 2'd0, 0, 4'd0, 8'd0);
    step();
    step();
    chk("midrun busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    chk_all("async_reset", 2'd0, 0, 4'd0, 0, 0, 3'd0);
    step();
    rst = 1'b1;
    step();
    chk_all("post_reset", 2'd0, 0, 4'd0, 0, 0, 3'd0);
    chk("post_reset ready", cmd_ready, 1'b1);

`ifdef SEQ_LOOP_EN
    // Two looped commands (dwell 2 and 3) replay forever, level stays 2
    drive(1, 2'd0, 0, 4'd0, 8'd4);
    step();
    drive(1, 2'd2, 0, 4'd0, 8'd2);
    step();
    drive(1, 2'd3, 0, 4'd0, 8'd3);
    step();
    drive(0, 2'd0, 0, 4'd0, 8'd0);
    loop_en = 1'b1;
    #1;
    chk("loop ready", cmd_ready, 1'b0);
    step();
    chk("loop pre ctrl", control_signals, 2'd0);
    step();
    chk("loop pre2 ctrl", control_signals, 2'd0);
    for (int k = 0; k < 15; k++) begin
      step();
      chk($sformatf("loop%0d ctrl", k), control_signals, ((k % 5) < 2) ? 2'd2 : 2'd3);
      chk($sformatf("loop%0d level", k), fifo_level, 3'd2);
    end
    gameover = 1'b1;
    step();
    chk("loop flush level", fifo_level, 3'd0);
    gameover = 1'b0;
    loop_en  = 1'b0;
    resume   = 1'b1;
    step();
    resume = 1'b0;
    chk("loop exit halted", halted, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
